// File: rtl/mips_decode_operand_stage.sv
//============================================================================
// Module      : mips_decode_operand_stage
// Description : Decode-stage operand unit. Drives register file read
//               addresses, resolves operands against in-flight EX/MEM/WB
//               writes, detects load-use hazards and owns the ID/EX register.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module mips_decode_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // IF/ID entry
    input  logic              inValid,
    input  logic [31:0]       inInstr,
    input  logic [DATA_W-1:0] inPc,
    output logic              inReady,
    // register file read ports
    output logic [ADDR_W-1:0] rd1Addr,
    output logic [ADDR_W-1:0] rd2Addr,
    input  logic [DATA_W-1:0] rd1Data,
    input  logic [DATA_W-1:0] rd2Data,
    // in-flight writers
    input  logic [DATA_W-1:0] exResult,
    input  logic [ADDR_W-1:0] memWrAddr,
    input  logic              memWrEnable,
    input  logic              memDataValid,
    input  logic [DATA_W-1:0] memWrData,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic              wrEnable,
    input  logic [DATA_W-1:0] wrData,
    // execute-stage handshake
    input  logic              exReady,
    input  logic              flush,
    // ID/EX register
    output logic              outValid,
    output logic [DATA_W-1:0] outPc,
    output logic [31:0]       outInstr,
    output logic [DATA_W-1:0] outRsVal,
    output logic [DATA_W-1:0] outRtVal,
    output logic [ADDR_W-1:0] outDest,
    output logic              outWrEnable,
    output logic              outIsLoad,
    output logic [CNT_W-1:0]  stallCount
);

    logic [5:0]                  w_op;
    logic [5:0]                  w_funct;
    logic                        w_uses_rs;
    logic                        w_uses_rt;
    logic                        w_is_load;
    logic                        w_writes;
    logic [ADDR_W-1:0]           w_dest;
    logic [1:0][ADDR_W-1:0]      w_src;
    logic [1:0][DATA_W-1:0]      w_file;
    logic [1:0][DATA_W-1:0]      w_val;
    logic [1:0]                  w_haz;
    logic                        w_hazard;
    logic                        w_load_entry;

    assign w_op    = inInstr[31:26];
    assign w_funct = inInstr[5:0];

    assign rd1Addr = ADDR_W'(inInstr[25:21]);
    assign rd2Addr = ADDR_W'(inInstr[20:16]);

    assign w_src[0]  = rd1Addr;
    assign w_src[1]  = rd2Addr;
    assign w_file[0] = rd1Data;
    assign w_file[1] = rd2Data;

    // Instruction field decode: source usage, destination, write and load flags
    always_comb begin
        w_uses_rs = !(w_op inside {6'h02, 6'h03, 6'h0F});
        w_uses_rt = w_op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
        w_is_load = w_op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        if (w_op == 6'h00) begin
            w_dest = ADDR_W'(inInstr[15:11]);
        end else if (w_op == 6'h03) begin
            w_dest = ADDR_W'(31);
        end else begin
            w_dest = ADDR_W'(inInstr[20:16]);
        end
        w_writes = ((w_op == 6'h00) && (w_funct != 6'h08))
                 || ((w_op >= 6'h08) && (w_op <= 6'h0F))
                 || w_is_load
                 || (w_op == 6'h03);
        if (w_dest == '0) begin
            w_writes = 1'b0;
        end
    end

    // Operand resolution: youngest in-flight writer wins; the file itself has
    // no write-through, so the WB bypass is the last stop before file data
    always_comb begin
        w_val = w_file;
        w_haz = '0;
        for (int i = 0; i < 2; i++) begin
            if (w_src[i] == '0) begin
                w_val[i] = '0;
            end else if (outValid && outWrEnable && (outDest == w_src[i])) begin
                w_val[i] = exResult;
                w_haz[i] = outIsLoad;
            end else if (memWrEnable && (memWrAddr == w_src[i])) begin
                w_val[i] = memWrData;
                w_haz[i] = !memDataValid;
            end else if (wrEnable && (wrAddr == w_src[i])) begin
                w_val[i] = wrData;
            end
        end
    end

    assign w_hazard     = inValid && ((w_uses_rs && w_haz[0]) || (w_uses_rt && w_haz[1]));
    assign inReady      = exReady && !w_hazard && !flush;
    assign w_load_entry = exReady && inValid && !w_hazard;

    // ID/EX register: flush kills, accepted entry loads, otherwise bubble or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid    <= 1'b0;
            outPc       <= '0;
            outInstr    <= '0;
            outRsVal    <= '0;
            outRtVal    <= '0;
            outDest     <= '0;
            outWrEnable <= 1'b0;
            outIsLoad   <= 1'b0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (w_load_entry) begin
            outValid    <= 1'b1;
            outPc       <= inPc;
            outInstr    <= inInstr;
            outRsVal    <= w_val[0];
            outRtVal    <= w_val[1];
            outDest     <= w_dest;
            outWrEnable <= w_writes;
            outIsLoad   <= w_is_load;
        end else if (exReady) begin
            outValid <= 1'b0;
        end
    end

    // Saturating count of cycles lost to hazards while execute could accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCount <= '0;
        end else if (w_hazard && exReady && !flush && (stallCount != {CNT_W{1'b1}})) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_decode_operand_stage.sv
//============================================================================
// Module      : tb_mips_decode_operand_stage
// Description : Self-checking bench for mips_decode_operand_stage with a
//               behavioural register file and pending-write reference model.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_decode_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inValid, flush, exReady;
    logic [31:0] inInstr, inPc, exResult, memWrData, wrData;
    logic [4:0]  memWrAddr, wrAddr;
    logic        memWrEnable, memDataValid, wrEnable;
    logic [31:0] rd1Data, rd2Data;

    logic        inReady, outValid, outWrEnable, outIsLoad;
    logic [4:0]  rd1Addr, rd2Addr, outDest;
    logic [31:0] outPc, outInstr, outRsVal, outRtVal;
    logic [15:0] stallCount;

    logic        s_inReady, s_outValid, s_outWrEnable, s_outIsLoad;
    logic [4:0]  s_rd1Addr, s_rd2Addr, s_outDest;
    logic [31:0] s_outPc, s_outInstr, s_outRsVal, s_outRtVal;
    logic [1:0]  s_stallCount;

    logic [31:0] rf [32];
    assign rd1Data = rf[rd1Addr];
    assign rd2Data = rf[rd2Addr];

    int total = 0;
    int bad   = 0;

    // reference ID/EX state
    logic        m_valid, m_we, m_load, m_urs, m_urt;
    logic [4:0]  m_dest;
    logic [31:0] m_pc, m_instr, m_rs, m_rt;
    int          m_stall, m_stall2;

    always #5 clk = ~clk;

    mips_decode_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inInstr(inInstr), .inPc(inPc),
        .inReady(inReady), .rd1Addr(rd1Addr), .rd2Addr(rd2Addr), .rd1Data(rd1Data),
        .rd2Data(rd2Data), .exResult(exResult), .memWrAddr(memWrAddr),
        .memWrEnable(memWrEnable), .memDataValid(memDataValid), .memWrData(memWrData),
        .wrAddr(wrAddr), .wrEnable(wrEnable), .wrData(wrData), .exReady(exReady),
        .flush(flush), .outValid(outValid), .outPc(outPc), .outInstr(outInstr),
        .outRsVal(outRsVal), .outRtVal(outRtVal), .outDest(outDest),
        .outWrEnable(outWrEnable), .outIsLoad(outIsLoad), .stallCount(stallCount)
    );

    mips_decode_operand_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inInstr(inInstr), .inPc(inPc),
        .inReady(s_inReady), .rd1Addr(s_rd1Addr), .rd2Addr(s_rd2Addr), .rd1Data(rd1Data),
        .rd2Data(rd2Data), .exResult(exResult), .memWrAddr(memWrAddr),
        .memWrEnable(memWrEnable), .memDataValid(memDataValid), .memWrData(memWrData),
        .wrAddr(wrAddr), .wrEnable(wrEnable), .wrData(wrData), .exReady(exReady),
        .flush(flush), .outValid(s_outValid), .outPc(s_outPc), .outInstr(s_outInstr),
        .outRsVal(s_outRsVal), .outRtVal(s_outRtVal), .outDest(s_outDest),
        .outWrEnable(s_outWrEnable), .outIsLoad(s_outIsLoad), .stallCount(s_stallCount)
    );

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Instruction semantics straight from the opcode tables
    function automatic void m_decode(input logic [31:0] ins, output logic urs, output logic urt,
                                     output logic [4:0] dst, output logic wr, output logic ld);
        logic [5:0] op;
        op  = ins[31:26];
        ld  = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        urs = !(op inside {6'h02, 6'h03, 6'h0F});
        urt = op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
        dst = (op == 6'h00) ? ins[15:11] : (op == 6'h03) ? 5'd31 : ins[20:16];
        wr  = ((op == 6'h00 && ins[5:0] != 6'h08) || (op >= 6'h08 && op <= 6'h0F) || ld
               || op == 6'h03) && (dst != 5'd0);
    endfunction

    // Value of register s = newest pending write (EX, MEM, WB order), else the file
    function automatic void m_resolve(input logic [4:0] s, output logic [31:0] v, output logic h);
        logic        en [3];
        logic [4:0]  ad [3];
        logic [31:0] dt [3];
        logic        pd [3];
        logic        found;
        en[0] = m_valid && m_we; ad[0] = m_dest;    dt[0] = exResult;  pd[0] = m_load;
        en[1] = memWrEnable;     ad[1] = memWrAddr; dt[1] = memWrData; pd[1] = !memDataValid;
        en[2] = wrEnable;        ad[2] = wrAddr;    dt[2] = wrData;    pd[2] = 1'b0;
        v = rf[s];
        h = 1'b0;
        found = 1'b0;
        if (s == 5'd0) begin
            v = 32'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!found && en[i] && ad[i] == s) begin
                    v = dt[i];
                    h = pd[i];
                    found = 1'b1;
                end
            end
        end
    endfunction

    task automatic set_idle();
        inValid = 0; inInstr = 0; inPc = 0; exResult = 0; memWrAddr = 0; memWrEnable = 0;
        memDataValid = 1; memWrData = 0; wrAddr = 0; wrEnable = 0; wrData = 0;
        exReady = 1; flush = 0;
    endtask

    // One clock; the behavioural file takes the WB write after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (wrEnable && wrAddr != 5'd0) rf[wrAddr] = wrData;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        m_valid = 0; m_we = 0; m_load = 0; m_dest = 0; m_pc = 0; m_instr = 0;
        m_rs = 0; m_rt = 0; m_urs = 1; m_urt = 1; m_stall = 0; m_stall2 = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        #1;
        total++;
        if ({outValid, outPc, outInstr, outRsVal, outRtVal, outDest, outWrEnable, outIsLoad} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%0b pc=%h ins=%h rs=%h rt=%h d=%0d we=%0b ld=%0b, want all 0",
                     outValid, outPc, outInstr, outRsVal, outRtVal, outDest, outWrEnable, outIsLoad);
        end
        total++;
        if (stallCount !== 16'd0) begin
            bad++; $display("FAIL reset_stall: got %0d want 0", stallCount);
        end
        do_reset();
    endtask

    task automatic test_wb_bypass();
        do_reset();
        rf[5] = 32'h11;
        inValid = 1; inInstr = rtype(5, 0, 3, 32'h20); inPc = 32'h400;
        wrEnable = 1; wrAddr = 5; wrData = 32'hAA;
        #1;
        total++;
        if (rd1Addr !== 5'd5 || rd2Addr !== 5'd0 || inReady !== 1'b1) begin
            bad++; $display("FAIL wb_comb: got rd1=%0d rd2=%0d rdy=%0b want 5 0 1", rd1Addr, rd2Addr, inReady);
        end
        tick();
        total++;
        if (outRsVal !== 32'hAA || outRtVal !== 32'h0 || outDest !== 5'd3 || outValid !== 1'b1
            || outWrEnable !== 1'b1 || outPc !== 32'h400) begin
            bad++; $display("FAIL wb_bypass: got rs=%h rt=%h d=%0d v=%0b we=%0b pc=%h want aa 0 3 1 1 400",
                            outRsVal, outRtVal, outDest, outValid, outWrEnable, outPc);
        end
    endtask

    task automatic test_priority();
        set_idle();
        inValid = 1; inInstr = itype(8, 0, 4, 7);
        tick();
        inInstr = rtype(4, 4, 7, 32'h20); exResult = 32'h1;
        memWrEnable = 1; memWrAddr = 4; memWrData = 32'h2; memDataValid = 1;
        wrEnable = 1; wrAddr = 4; wrData = 32'h3;
        tick();
        total++;
        if (outRsVal !== 32'h1 || outRtVal !== 32'h1 || outDest !== 5'd7) begin
            bad++; $display("FAIL priority_ex: got rs=%h rt=%h d=%0d want 1 1 7", outRsVal, outRtVal, outDest);
        end
        set_idle();
        inValid = 1; inInstr = itype(8, 0, 0, 5);
        tick();
        total++;
        if (outValid !== 1'b1 || outWrEnable !== 1'b0 || outDest !== 5'd0) begin
            bad++; $display("FAIL dest_r0: got v=%0b we=%0b d=%0d want 1 0 0", outValid, outWrEnable, outDest);
        end
        inInstr = rtype(0, 0, 8, 32'h20); exResult = 32'h55;
        memWrEnable = 1; memWrAddr = 0; memWrData = 32'h66;
        wrEnable = 1; wrAddr = 0; wrData = 32'h77;
        tick();
        total++;
        if (outRsVal !== 32'h0 || outRtVal !== 32'h0) begin
            bad++; $display("FAIL read_r0: got rs=%h rt=%h want 0 0", outRsVal, outRtVal);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        inValid = 1; inInstr = itype(32'h23, 1, 2, 0);
        tick();
        total++;
        if (outIsLoad !== 1'b1 || outDest !== 5'd2 || outWrEnable !== 1'b1) begin
            bad++; $display("FAIL lw_entry: got ld=%0b d=%0d we=%0b want 1 2 1", outIsLoad, outDest, outWrEnable);
        end
        inInstr = rtype(2, 2, 6, 32'h20);
        #1;
        total++;
        if (inReady !== 1'b0) begin
            bad++; $display("FAIL lu_ready: got %0b want 0", inReady);
        end
        tick();
        total++;
        if (outValid !== 1'b0 || stallCount !== 16'd1) begin
            bad++; $display("FAIL lu_bubble: got v=%0b stall=%0d want 0 1", outValid, stallCount);
        end
        memWrEnable = 1; memWrAddr = 2; memDataValid = 1; memWrData = 32'h1234;
        #1;
        total++;
        if (inReady !== 1'b1) begin
            bad++; $display("FAIL lu_release: got %0b want 1", inReady);
        end
        tick();
        total++;
        if (outValid !== 1'b1 || outRsVal !== 32'h1234 || outRtVal !== 32'h1234 || stallCount !== 16'd1) begin
            bad++; $display("FAIL lu_forward: got v=%0b rs=%h rt=%h stall=%0d want 1 1234 1234 1",
                            outValid, outRsVal, outRtVal, stallCount);
        end
    endtask

    task automatic test_backpressure();
        memWrEnable = 0; exReady = 0; inInstr = rtype(1, 1, 9, 32'h20);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (inReady !== 1'b0) begin
                bad++; $display("FAIL bp_ready: cycle %0d got %0b want 0", c, inReady);
            end
            tick();
            total++;
            if (outValid !== 1'b1 || outDest !== 5'd6 || outRsVal !== 32'h1234 || stallCount !== 16'd1) begin
                bad++; $display("FAIL bp_hold: cycle %0d got v=%0b d=%0d rs=%h stall=%0d want 1 6 1234 1",
                                c, outValid, outDest, outRsVal, stallCount);
            end
        end
    endtask

    task automatic test_flush();
        set_idle();
        inValid = 1; flush = 1; inInstr = itype(8, 0, 5, 1);
        #1;
        total++;
        if (inReady !== 1'b0) begin
            bad++; $display("FAIL flush_ready: got %0b want 0", inReady);
        end
        tick();
        total++;
        if (outValid !== 1'b0) begin
            bad++; $display("FAIL flush_drop: got v=%0b want 0", outValid);
        end
        flush = 0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        inValid = 1; inInstr = itype(32'h23, 1, 2, 0);
        tick();
        inInstr = rtype(2, 2, 6, 32'h20);
        memWrEnable = 1; memWrAddr = 2; memDataValid = 0;
        tick();
        tick();
        total++;
        if (stallCount !== 16'd2) begin
            bad++; $display("FAIL stall_pre_reset: got %0d want 2", stallCount);
        end
        #2;
        rst_n = 0;
        #1;
        total++;
        if ({outValid, outPc, outInstr, outRsVal, outRtVal, outDest, outWrEnable, outIsLoad, stallCount} !== '0) begin
            bad++; $display("FAIL async_reset: got v=%0b d=%0d we=%0b ld=%0b stall=%0d want all 0",
                            outValid, outDest, outWrEnable, outIsLoad, stallCount);
        end
        rst_n = 1;
    endtask

    task automatic test_saturation();
        do_reset();
        inValid = 1; inInstr = itype(32'h23, 1, 2, 0);
        tick();
        inInstr = rtype(2, 2, 6, 32'h20);
        memWrEnable = 1; memWrAddr = 2; memDataValid = 0;
        for (int c = 0; c < 5; c++) tick();
        total++;
        if (s_stallCount !== 2'd3 || stallCount !== 16'd5) begin
            bad++; $display("FAIL saturation: got narrow=%0d wide=%0d want 3 5", s_stallCount, stallCount);
        end
    endtask

    task automatic test_random(input int n);
        logic [5:0]  ops [14] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D,
                                  6'h0F, 6'h20, 6'h23, 6'h24, 6'h28, 6'h2B};
        logic        urs, urt, wr, ld, hrs, hrt, hz, exp_ready;
        logic [4:0]  dst;
        logic [31:0] vrs, vrt;
        do_reset();
        for (int c = 0; c < n; c++) begin
            inValid      = ($urandom_range(0, 99) < 85);
            inInstr      = {ops[$urandom_range(0, 13)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom), ($urandom_range(0, 3) == 0) ? 6'h08 : 6'h20};
            inPc         = $urandom;
            exResult     = $urandom;
            memWrEnable  = $urandom_range(0, 1) == 1;
            memWrAddr    = 5'($urandom_range(0, 7));
            memDataValid = $urandom_range(0, 3) != 0;
            memWrData    = $urandom;
            wrEnable     = $urandom_range(0, 1) == 1;
            wrAddr       = 5'($urandom_range(0, 7));
            wrData       = $urandom;
            exReady      = $urandom_range(0, 4) != 0;
            flush        = $urandom_range(0, 19) == 0;
            #1;
            m_decode(inInstr, urs, urt, dst, wr, ld);
            m_resolve(inInstr[25:21], vrs, hrs);
            m_resolve(inInstr[20:16], vrt, hrt);
            hz = inValid && ((urs && hrs) || (urt && hrt));
            exp_ready = exReady && !hz && !flush;
            total++;
            if (inReady !== exp_ready || rd1Addr !== inInstr[25:21] || rd2Addr !== inInstr[20:16]) begin
                bad++; $display("FAIL rnd_comb: cycle %0d got rdy=%0b rd1=%0d rd2=%0d want %0b %0d %0d",
                                c, inReady, rd1Addr, rd2Addr, exp_ready, inInstr[25:21], inInstr[20:16]);
            end
            if (hz && exReady && !flush) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall2 < 3) m_stall2++;
            end
            if (flush) begin
                m_valid = 0;
            end else if (exReady && inValid && !hz) begin
                m_valid = 1; m_pc = inPc; m_instr = inInstr; m_rs = vrs; m_rt = vrt;
                m_dest = dst; m_we = wr; m_load = ld; m_urs = urs; m_urt = urt;
            end else if (exReady) begin
                m_valid = 0;
            end
            tick();
            total++;
            if (outValid !== m_valid || outPc !== m_pc || outInstr !== m_instr || outDest !== m_dest
                || outWrEnable !== m_we || outIsLoad !== m_load) begin
                bad++; $display("FAIL rnd_entry: cycle %0d got v=%0b pc=%h d=%0d we=%0b ld=%0b want %0b %h %0d %0b %0b",
                                c, outValid, outPc, outDest, outWrEnable, outIsLoad,
                                m_valid, m_pc, m_dest, m_we, m_load);
            end
            total++;
            if ((m_urs && outRsVal !== m_rs) || (m_urt && outRtVal !== m_rt)) begin
                bad++; $display("FAIL rnd_operands: cycle %0d got rs=%h rt=%h want %h %h",
                                c, outRsVal, outRtVal, m_rs, m_rt);
            end
            total++;
            if (stallCount !== 16'(m_stall) || s_stallCount !== 2'(m_stall2)) begin
                bad++; $display("FAIL rnd_stall: cycle %0d got %0d/%0d want %0d/%0d",
                                c, stallCount, s_stallCount, m_stall, m_stall2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h1000 + 32'(i);
        test_reset();
        test_wb_bypass();
        test_priority();
        test_load_use();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        test_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_decode_operand_stage.md
Name: mips_decode_operand_stage

Overview:
- Decode-stage operand unit sitting directly downstream of the register file.
- Drives the file's two read addresses from the IF/ID instruction and resolves the returned operands against in-flight writes (EX, MEM, WB). The register file has no internal write-through, so WB bypass happens here.
- Detects load-use hazards and holds the ID/EX pipeline register consumed by the execute stage.

Parameters:
- DATA_W, 32, operand/PC width.
- ADDR_W, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- ctrl  input  control bundle  Clock field: single rising-edge clock. Reset field: asynchronous, active-low.
- inValid  input  1  IF/ID entry valid.
- inInstr  input  32  IF/ID instruction.
- inPc  input  DATA_W  IF/ID PC.
- inReady  output  1  stage accepts IF/ID entry this cycle.
- rd1Addr  output  ADDR_W  to register file; equals inInstr[25:21] (rs).
- rd2Addr  output  ADDR_W  to register file; equals inInstr[20:16] (rt).
- rd1Data  input  DATA_W  register file read data, port 1.
- rd2Data  input  DATA_W  register file read data, port 2.
- exResult  input  DATA_W  combinational ALU result of the current ID/EX entry.
- memWrAddr  input  ADDR_W  MEM-stage destination.
- memWrEnable  input  1  MEM-stage writes a register.
- memDataValid  input  1  memWrData is final; 0 for a load whose data is still pending.
- memWrData  input  DATA_W  MEM-stage result.
- wrAddr  input  ADDR_W  WB destination (same bus as register file write port).
- wrEnable  input  1  WB write enable.
- wrData  input  DATA_W  WB write data.
- exReady  input  1  execute stage accepts the ID/EX entry.
- flush  input  1  kill ID/EX entry and incoming entry.
- outValid  output  1  ID/EX entry valid.
- outPc  output  DATA_W  ID/EX PC.
- outInstr  output  32  ID/EX instruction.
- outRsVal  output  DATA_W  resolved rs operand.
- outRtVal  output  DATA_W  resolved rt operand.
- outDest  output  ADDR_W  ID/EX destination register.
- outWrEnable  output  1  ID/EX entry writes a register.
- outIsLoad  output  1  ID/EX entry is a load.
- stallCount  output  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Decode, from op = inInstr[31:26].
  - usesRs: all opcodes except 0x02, 0x03, 0x0F.
  - usesRt: op 0x00, 0x04, 0x05, 0x28, 0x29, 0x2B.
  - dest: rd for op 0x00; 31 for op 0x03; otherwise rt.
  - writes: op 0x00 with funct != 0x08; op 0x08–0x0F; loads; op 0x03. Forced to 0 when dest == 0.
  - isLoad: op in {0x20, 0x21, 0x23, 0x24, 0x25}.
- Operand resolution, per used source s, highest priority first:
  1. s == 0 → 0.
  2. outValid && outWrEnable && outDest == s → exResult, or hazard if outIsLoad.
  3. memWrEnable && memWrAddr == s → memWrData, or hazard if !memDataValid.
  4. wrEnable && wrAddr == s → wrData.
  5. Register file data.
- Unused sources never raise hazard.
- hazard = inValid && any used source hazards.
- inReady = exReady && !hazard && !flush (combinational).
- Per posedge:
  - flush: outValid ← 0 (takes priority over everything).
  - Else if exReady && inValid && !hazard: load all out* from decode/resolution; outValid ← 1.
  - Else if exReady: outValid ← 0 (bubble). Data fields hold.
  - Else (!exReady): hold all out*.
- stallCount increments on each cycle with hazard && exReady && !flush; saturates at all-ones, no wrap.
- Reset (asynchronous, active-low): outValid, outWrEnable, outIsLoad, outDest, outPc, outInstr, outRsVal, outRtVal, stallCount ← 0. Reset mid-stall discards the held entry. Outputs are stable from the first edge after deassertion.
- rd1Addr/rd2Addr are combinational from inInstr regardless of inValid.
- Simultaneous WB write and read of the same register returns wrData, never stale file data.
- Latency: 1 cycle IF/ID → ID/EX when no hazard.

Test Plan:
- WB bypass: file r5 = 0x11, wrEnable with wrAddr = 5, wrData = 0xAA, inInstr = add r3,r5,r0 → next cycle outRsVal = 0xAA, outDest = 3, outValid = 1.
- Priority: EX entry dest r4 with exResult = 0x1, MEM r4 = 0x2, WB r4 = 0x3; consumer of r4 → outRsVal = 0x1. Dest r0 entries never forward, and reading r0 gives 0.
- Load-use: lw r2 in ID/EX, next instruction add r6,r2,r2 → inReady = 0 for 1 cycle, bubble (outValid = 0), stallCount = 1. Next cycle the value is forwarded from memWrData with memDataValid = 1.
- Backpressure: exReady = 0 for 3 cycles with a valid entry → out* unchanged, inReady = 0, stallCount unchanged.
- Flush with inValid = 1 and exReady = 1 → outValid = 0 next cycle, entry dropped. Reset asserted mid-stall → all outputs 0 immediately, without waiting for a clock edge.
- Saturation: CNT_W = 2, 5 hazard cycles → stallCount = 3.
